// File: rtl/gcd_arbiter_pkg.sv
// Shared definitions for the GCD engine arbiter: controller state encoding and
// the width helper used for requester indices and the round-robin pointer.
package gcd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gcd_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans the request vector starting at the pointer and
// returns the first requester found as a one-hot grant plus its index.
module gcd_arbiter_rr_arbiter
  import gcd_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  always_comb begin
    int              j;
    logic [IDXW-1:0] sel;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      sel = j[IDXW-1:0];
      if (!any && req[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        idx        = sel;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one GCD engine between NREQ requesters with round-robin arbitration,
// one-entry response slots per requester and a bypass for a zero first operand.
module gcd_arbiter
  import gcd_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int CNTW  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [NREQ*WIDTH-1:0]   rsp_data,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic                    eng_in_valid,
  output logic [2*WIDTH-1:0]      eng_in_data,
  input  logic                    eng_in_ready,
  input  logic                    eng_out_valid,
  input  logic [WIDTH-1:0]        eng_out_data,
  output logic                    busy,
  output logic [CNTW-1:0]         done_count
);

  localparam int IDXW = idx_width(NREQ);

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] owner;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] ptr_next;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] win_grant;
  logic            win_any;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;

  // A requester whose slot is still full cannot be granted, so a slot is
  // never set and cleared in the same cycle.
  assign elig = req_valid & ~rsp_valid;

  gcd_arbiter_rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req   (elig),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign req_ready = (state == ST_IDLE && !reset) ? win_grant : '0;
  assign win_a     = req_a[int'(win_idx)*WIDTH +: WIDTH];
  assign win_b     = req_b[int'(win_idx)*WIDTH +: WIDTH];
  assign ptr_next  = (int'(win_idx) == NREQ-1) ? '0 : win_idx + IDXW'(1);
  assign busy      = (state != ST_IDLE);

  // Operand and owner capture at the grant; payload only, no reset needed.
  always_ff @(posedge clk) begin
    if (|req_ready) begin
      owner       <= win_idx;
      eng_in_data <= {win_b, win_a};
    end
  end

  // Controller, response slots and completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      eng_in_valid <= 1'b0;
      done_count   <= '0;
    end else begin
      rsp_valid <= rsp_valid & ~rsp_ready;
      unique case (state)
        ST_IDLE: begin
          if (win_any) begin
            ptr <= ptr_next;
            // The engine never terminates on a==0, so answer b directly.
            if (win_a == '0) begin
              rsp_data[int'(win_idx)*WIDTH +: WIDTH] <= win_b;
              rsp_valid[win_idx] <= 1'b1;
              done_count         <= done_count + CNTW'(1);
            end else begin
              eng_in_valid <= 1'b1;
              state        <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (eng_in_ready) begin
            eng_in_valid <= 1'b0;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (eng_out_valid) begin
            rsp_data[int'(owner)*WIDTH +: WIDTH] <= eng_out_data;
            rsp_valid[owner] <= 1'b1;
            done_count       <= done_count + CNTW'(1);
            state            <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: behavioural GCD engine, cycle-level reference model of
// the arbiter's rules, directed scenarios followed by a randomized soak.
module tb_gcd_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int CNTW  = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b, rsp_data;
  logic                  eng_in_valid, eng_in_ready, eng_ov, stray_ov, eov, busy;
  logic [2*WIDTH-1:0]    eng_in_data;
  logic [WIDTH-1:0]      eng_od;
  logic [CNTW-1:0]       done_count;

  int vectors     = 0;
  int miscompares = 0;
  bit eng_stall   = 1'b0;
  int eng_extra   = 0;

  assign eov = eng_ov | stray_ov;
  always #5 clk = ~clk;

  gcd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_ready     (rsp_ready),
    .eng_in_valid  (eng_in_valid),
    .eng_in_data   (eng_in_data),
    .eng_in_ready  (eng_in_ready),
    .eng_out_valid (eov),
    .eng_out_data  (eng_od),
    .busy          (busy),
    .done_count    (done_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int unsigned x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return WIDTH'(x);
  endfunction

  // Behavioural engine: subtraction GCD, random latency, one-cycle result pulse.
  initial begin
    logic hs, rs;
    logic [WIDTH-1:0] ea, eb_op, res;
    int cnt;
    bit eb;
    eng_ov = 1'b0; eng_od = '0; eng_in_ready = 1'b0;
    eb = 1'b0; cnt = 0; res = '0; ea = '0; eb_op = '0;
    forever begin
      @(negedge clk);
      hs = (eng_in_valid === 1'b1) && eng_in_ready;
      rs = (reset === 1'b1);
      if (hs) begin ea = eng_in_data[WIDTH-1:0]; eb_op = eng_in_data[2*WIDTH-1:WIDTH]; end
      @(posedge clk); #1;
      eng_ov = 1'b0;
      if (rs) eb = 1'b0;
      else if (eb) begin
        if (cnt == 0) begin eng_ov = 1'b1; eng_od = res; eb = 1'b0; end
        else cnt--;
      end else if (hs) begin
        eb = 1'b1;
        while (eb_op != 0) begin
          if (ea >= eb_op) ea = ea - eb_op;
          else begin res = ea; ea = eb_op; eb_op = res; end
        end
        res = ea;
        cnt = int'($urandom_range(0, 3)) + eng_extra;
      end
      eng_in_ready = !eb && !eng_stall && !rs;
    end
  end

  // Reference model: predicts every output for the current cycle, then advances.
  logic [NREQ-1:0]  m_valid;
  logic [WIDTH-1:0] m_data [NREQ];
  logic [CNTW-1:0]  m_done;
  logic [WIDTH-1:0] m_a, m_b;
  int m_ptr, m_phase, m_owner;

  always @(negedge clk) begin
    int w;
    logic [NREQ-1:0] exp_rr;
    if (reset === 1'b1) begin
      chk("rst_req_ready", req_ready, '0);
      m_valid = '0; m_done = '0; m_ptr = 0; m_phase = 0; m_owner = 0;
      for (int i = 0; i < NREQ; i++) m_data[i] = '0;
    end else begin
      chk("rsp_valid", rsp_valid, m_valid);
      for (int i = 0; i < NREQ; i++)
        if (m_valid[i]) chk("rsp_data", rsp_data[i*WIDTH +: WIDTH], m_data[i]);
      chk("done_count", done_count, m_done);
      chk("busy", busy, m_phase != 0);
      chk("eng_in_valid", eng_in_valid, m_phase == 1);
      if (m_phase == 1) chk("eng_in_data", eng_in_data, {m_b, m_a});
      w = -1;
      if (m_phase == 0)
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (m_ptr + k) % NREQ;
          if (w < 0 && req_valid[j] && !m_valid[j]) w = j;
        end
      exp_rr = '0;
      if (w >= 0) exp_rr[w] = 1'b1;
      chk("req_ready", req_ready, exp_rr);
      m_valid = m_valid & ~rsp_ready;
      case (m_phase)
        0: if (w >= 0) begin
          m_ptr = (w + 1) % NREQ;
          m_a = req_a[w*WIDTH +: WIDTH];
          m_b = req_b[w*WIDTH +: WIDTH];
          m_owner = w;
          if (m_a == 0) begin
            m_valid[w] = 1'b1; m_data[w] = m_b; m_done = m_done + 1;
          end else m_phase = 1;
        end
        1: if (eng_in_ready) m_phase = 2;
        default: if (eov) begin
          m_valid[m_owner] = 1'b1;
          m_data[m_owner] = ref_gcd(m_a, m_b);
          m_done = m_done + 1;
          m_phase = 0;
        end
      endcase
    end
  end

  // Last value seen in each response slot.
  logic [WIDTH-1:0] seen_data [NREQ] = '{default: '0};
  always @(negedge clk)
    if (reset === 1'b0)
      for (int i = 0; i < NREQ; i++)
        if (rsp_valid[i] === 1'b1) seen_data[i] = rsp_data[i*WIDTH +: WIDTH];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
        break;
      end
    end
    if (idx < 0) chk("grant_timeout", 0, 1);
    step();
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy && (req_valid & ~rsp_valid) == '0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    step(); step(); step();
  endtask

  initial begin
    int w;
    int ord3[5] = '{0, 1, 2, 3, 0};
    int ord4[3] = '{2, 3, 0};
    logic [NREQ-1:0] gr;
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = '1; stray_ov = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, '0);
    chk("reset_rsp_data", rsp_data, '0);
    chk("reset_done", done_count, '0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_eng_in_valid", eng_in_valid, 1'b0);

    // Single engine operation, 48/18 -> 6.
    step(); set_req(0, 16'd48, 16'd18);
    @(negedge clk); chk("t1_grant", req_ready, 4'b0001);
    step(); req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_issue_valid", eng_in_valid, 1'b1);
    chk("t1_issue_data", eng_in_data, 32'h0012_0030);
    wait_idle();
    chk("t1_result", seen_data[0], 16'd6);
    chk("t1_done", done_count, 1);

    // Zero first operand bypasses the engine.
    set_req(2, 16'd0, 16'd7);
    @(negedge clk); chk("t2_grant", req_ready, 4'b0100);
    step(); req_valid[2] = 1'b0;
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid[2], 1'b1);
    chk("t2_rsp_data", rsp_data[2*WIDTH +: WIDTH], 16'd7);
    chk("t2_no_issue", eng_in_valid, 1'b0);
    step(); set_req(2, 16'd0, 16'd0);
    @(negedge clk); chk("t2z_grant", req_ready, 4'b0100);
    step(); req_valid[2] = 1'b0;
    @(negedge clk);
    chk("t2z_rsp_valid", rsp_valid[2], 1'b1);
    chk("t2z_rsp_data", rsp_data[2*WIDTH +: WIDTH], 16'd0);
    step(); set_req(3, 16'd0, 16'd9);
    wait_grant(w); chk("t2_ptr_wrap", w, 3);
    req_valid[3] = 1'b0;

    // All four requesters at once.
    set_req(0, 16'd12, 16'd8); set_req(1, 16'd9, 16'd6);
    set_req(2, 16'd35, 16'd14); set_req(3, 16'd5, 16'd0);
    for (int g = 0; g < 5; g++) begin
      wait_grant(w);
      chk("t3_order", w, ord3[g]);
      if (g == 1) chk("t3_slot0_first", seen_data[0], 16'd4);
      if (g == 0) set_req(0, 16'd21, 16'd15);
      else if (w >= 0) req_valid[w] = 1'b0;
    end
    wait_idle();
    chk("t3_slot0", seen_data[0], 16'd3);
    chk("t3_slot1", seen_data[1], 16'd3);
    chk("t3_slot2", seen_data[2], 16'd7);
    chk("t3_slot3", seen_data[3], 16'd5);
    chk("t3_done", done_count, 9);

    // Full slot blocks its requester while others proceed.
    rsp_ready[1] = 1'b0;
    set_req(1, 16'd10, 16'd4);
    wait_grant(w); chk("t4_first", w, 1);
    set_req(1, 16'd27, 16'd18);
    set_req(0, 16'd8, 16'd12); set_req(2, 16'd14, 16'd21); set_req(3, 16'd0, 16'd6);
    for (int g = 0; g < 3; g++) begin
      wait_grant(w);
      chk("t4_order", w, ord4[g]);
      if (w >= 0) req_valid[w] = 1'b0;
    end
    wait_idle();
    @(negedge clk);
    chk("t4_held_valid", rsp_valid[1], 1'b1);
    chk("t4_held_data", rsp_data[WIDTH +: WIDTH], 16'd2);
    chk("t4_no_regrant", req_ready, '0);
    step(); rsp_ready[1] = 1'b1;
    wait_grant(w); chk("t4_release", w, 1);
    req_valid[1] = 1'b0;
    wait_idle();
    chk("t4_slot1", seen_data[1], 16'd9);
    chk("t4_slot0", seen_data[0], 16'd4);
    chk("t4_slot2", seen_data[2], 16'd7);
    chk("t4_slot3", seen_data[3], 16'd6);

    // Engine refuses input for five cycles.
    eng_stall = 1'b1; step();
    set_req(0, 16'd100, 16'd75);
    wait_grant(w); chk("t5_grant", w, 0);
    req_valid[0] = 1'b0;
    set_req(1, 16'd3, 16'd3); set_req(2, 16'd4, 16'd6); set_req(3, 16'd0, 16'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_hold_valid", eng_in_valid, 1'b1);
      chk("t5_hold_data", eng_in_data, {16'd75, 16'd100});
      chk("t5_no_grant", req_ready, '0);
    end
    step(); req_valid = '0; eng_stall = 1'b0;
    wait_idle();
    chk("t5_result", seen_data[0], 16'd25);

    // Reset while the engine is mid-computation, then a stray result pulse.
    eng_extra = 20;
    set_req(0, 16'd1000, 16'd250);
    wait_grant(w); req_valid[0] = 1'b0;
    w = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy && !eng_in_valid) begin w = 1; break; end
    end
    chk("t6_reached_wait", w, 1);
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 1'b0);
    chk("t6_rsp_valid", rsp_valid, '0);
    chk("t6_done", done_count, '0);
    step(); stray_ov = 1'b1;
    step(); stray_ov = 1'b0;
    @(negedge clk);
    chk("t6_stray_rsp", rsp_valid, '0);
    chk("t6_stray_done", done_count, '0);
    eng_extra = 0;
    step(); set_req(3, 16'd0, 16'd2); set_req(0, 16'd0, 16'd3);
    wait_grant(w); chk("t6_ptr_zero", w, 0);
    req_valid[0] = 1'b0;
    wait_grant(w); chk("t6_next", w, 3);
    req_valid[3] = 1'b0;
    wait_idle();

    // Randomized soak; the reference model checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); gr = req_ready;
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (gr[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, ($urandom_range(0, 9) == 0) ? 16'd0 : WIDTH'($urandom_range(1, 300)),
                     ($urandom_range(0, 7) == 0) ? 16'd0 : WIDTH'($urandom_range(0, 300)));
        else if (req_valid[i] && !gr[i] && $urandom_range(0, 50) == 0)
          req_valid[i] = 1'b0;
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      eng_stall = ($urandom_range(0, 7) == 0);
    end
    req_valid = '0; rsp_ready = '1; eng_stall = 1'b0;
    wait_idle();
    chk("final_idle", busy, 1'b0);
    chk("final_slots_drained", rsp_valid, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
